packet_tick_gen: RTL and testbench

//   Multi-channel programmable periodic/one-shot tick generator; generalises the fixed 1 s packet timer.

---
 rtl/packet_tick_gen.sv | 101 ++++++++++
 tb/tb_packet_tick_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/packet_tick_gen.sv
// Multi-channel programmable tick generator: each channel pulses tick every N clocks
// (periodic or one-shot), holds a pending flag until acked and flags overruns.
module packet_tick_gen #(
  parameter int NUM_CH         = 4,
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 50000000,
  parameter bit DEFAULT_EN     = 1'b1,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic              cfg_en,
  input  logic              cfg_oneshot,
  input  logic              restart,
  input  logic [NUM_CH-1:0] tick_ack,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] tick_pending,
  output logic [NUM_CH-1:0] overrun
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             en_q, en_d, os_q, os_d;
    logic             tick_q, tick_d, pend_q, pend_d, ovr_q, ovr_d;
    logic             wr, active, hit, fire;

    // Out-of-range indices never match any channel, so such writes are dropped.
    assign wr     = cfg_we && (cfg_ch == CH_W'(c));
    assign active = en_q && (period_q != '0);
    assign hit    = active && (cnt_q == period_q - WIDTH'(1));
    assign fire   = hit && !restart && !wr;

    always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      en_d     = en_q;
      os_d     = os_q;
      tick_d   = 1'b0;
      pend_d   = pend_q;
      ovr_d    = ovr_q;
      if (wr) begin
        period_d = cfg_period;
        en_d     = cfg_en;
        os_d     = cfg_oneshot;
        cnt_d    = '0;
        pend_d   = 1'b0;
        ovr_d    = 1'b0;
      end
      if (restart) begin
        cnt_d = '0;
      end else if (!wr) begin
        if (hit) begin
          tick_d = 1'b1;
          cnt_d  = '0;
          if (os_q) en_d = 1'b0;
        end else if (active) begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      if (!wr) begin
        // A tick coinciding with an ack leaves pending set and is not an overrun.
        if (fire) begin
          pend_d = 1'b1;
          if (pend_q && !tick_ack[c]) ovr_d = 1'b1;
        end else if (tick_ack[c]) begin
          pend_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q    <= '0;
        period_q <= DEF_P;
        en_q     <= DEFAULT_EN;
        os_q     <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        period_q <= period_d;
        en_q     <= en_d;
        os_q     <= os_d;
        tick_q   <= tick_d;
        pend_q   <= pend_d;
        ovr_q    <= ovr_d;
      end
    end

    assign tick[c]         = tick_q;
    assign tick_pending[c] = pend_q;
    assign overrun[c]      = ovr_q;
  end

endmodule

// File: tb/tb_packet_tick_gen.sv
// Directed bench for packet_tick_gen: three channels, 8-bit counters, default period 5.
module tb_packet_tick_gen;

  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [7:0]     cfg_period = '0;
  logic           cfg_en = 1'b0;
  logic           cfg_oneshot = 1'b0;
  logic           restart = 1'b0;
  logic [NCH-1:0] tick_ack = '0;
  logic [NCH-1:0] tick, tick_pending, overrun;

  int errs = 0;
  int checks = 0;

  packet_tick_gen #(
    .NUM_CH(NCH), .WIDTH(8), .DEFAULT_PERIOD(5), .DEFAULT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot), .restart(restart), .tick_ack(tick_ack),
    .tick(tick), .tick_pending(tick_pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] per, input logic en, input logic os);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_en = en; cfg_oneshot = os;
    edge1();
    cfg_we = 1'b0;
  endtask

  initial begin
    // 1: reset and default period 5 on every channel
    #2;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pend", 32'(tick_pending), 0);
    chk("rst_ovr", 32'(overrun), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      edge1();
      chk($sformatf("t1_tick_k%0d", k), 32'(tick), (k % 5 == 0) ? 32'd7 : 32'd0);
      if (k == 5)  chk("t1_pend", 32'(tick_pending), 7);
      if (k == 5)  chk("t1_ovr0", 32'(overrun), 0);
      if (k == 10) chk("t1_ovr", 32'(overrun), 7);
    end

    // 2: ch0 N=1 ticks every cycle, then N=0 halts it
    cfg(2'd0, 8'd1, 1'b1, 1'b0);
    chk("t2_wr_tick", 32'(tick[0]), 0);
    chk("t2_wr_pend", 32'(tick_pending[0]), 0);
    chk("t2_wr_ovr", 32'(overrun[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      edge1();
      chk($sformatf("t2_n1_k%0d", k), 32'(tick[0]), 1);
    end
    chk("t2_n1_ovr", 32'(overrun[0]), 1);
    cfg(2'd0, 8'd0, 1'b1, 1'b0);
    chk("t2_n0_wr", 32'(tick[0]), 0);
    for (int k = 1; k <= 3; k++) begin
      edge1();
      chk($sformatf("t2_n0_k%0d", k), 32'(tick[0]), 0);
    end

    // 3: ch1 one-shot N=3, then re-armed by a second write
    cfg(2'd1, 8'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      edge1();
      chk($sformatf("t3_os_k%0d", k), 32'(tick[1]), (k == 3) ? 32'd1 : 32'd0);
    end
    cfg(2'd1, 8'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      edge1();
      chk($sformatf("t3_rearm_k%0d", k), 32'(tick[1]), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("t3_pend", 32'(tick_pending[1]), 1);
    chk("t3_ovr", 32'(overrun[1]), 0);

    // 4: ch0 N=4 overrun on 2nd tick, ack coincident with 3rd tick
    cfg(2'd0, 8'd4, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) tick_ack = 3'b001;
      edge1();
      tick_ack = '0;
      chk($sformatf("t4_tick_k%0d", k), 32'(tick[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k == 4)  chk("t4_pend1", 32'(tick_pending[0]), 1);
      if (k == 4)  chk("t4_ovr1", 32'(overrun[0]), 0);
      if (k == 8)  chk("t4_ovr2", 32'(overrun[0]), 1);
      if (k == 12) chk("t4_pend_ack", 32'(tick_pending[0]), 1);
    end
    cfg(2'd0, 8'd4, 1'b1, 1'b0);
    chk("t4_wr_pend", 32'(tick_pending[0]), 0);
    chk("t4_wr_ovr", 32'(overrun[0]), 0);

    // 5: write on the would-tick edge suppresses it; out-of-range write ignored
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) tick_ack = 3'b001;
      edge1();
      tick_ack = '0;
      if (k == 4) chk("t5_tick", 32'(tick[0]), 1);
      if (k == 5) chk("t5_ack_only", 32'(tick_pending[0]), 0);
    end
    cfg(2'd0, 8'd4, 1'b1, 1'b0);
    chk("t5_suppress", 32'(tick[0]), 0);
    chk("t5_supp_pend", 32'(tick_pending[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd1; cfg_en = 1'b1; cfg_oneshot = 1'b0;
      end
      edge1();
      cfg_we = 1'b0;
      chk($sformatf("t5_after_k%0d", k), 32'(tick[0]), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("t5_oor_pend1", 32'(tick_pending[1]), 1);
    chk("t5_oor_tick1", 32'(tick[1]), 0);

    // 6: restart realigns ch0 (N=7) and ch1 (N=9); async reset clears outputs at once
    cfg(2'd0, 8'd7, 1'b1, 1'b0);
    cfg(2'd1, 8'd9, 1'b1, 1'b0);
    repeat (3) edge1();
    restart = 1'b1;
    edge1();
    restart = 1'b0;
    chk("t6_restart", 32'(tick[1:0]), 0);
    for (int k = 1; k <= 10; k++) begin
      edge1();
      chk($sformatf("t6_k%0d", k), 32'(tick[1:0]),
          32'({(k == 9) ? 1'b1 : 1'b0, (k == 7) ? 1'b1 : 1'b0}));
    end
    chk("t6_pend", 32'(tick_pending[1:0]), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_tick", 32'(tick), 0);
    chk("t6_arst_pend", 32'(tick_pending), 0);
    chk("t6_arst_ovr", 32'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
